// File: rtl/Bus.sv
`default_nettype none
// ============================================================================
//  Module      : Bus (package)
//  Description : OCP command/response encodings and a width helper shared by
//                the bus fabric blocks.
//  Revision    : 1.0 - initial release
// ============================================================================
package Bus;

    // OCP MCmd encodings
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        WR   = 3'd1,
        RD   = 3'd2,
        RDEX = 3'd3,
        RDL  = 3'd4,
        WRNP = 3'd5,
        WRC  = 3'd6,
        BCST = 3'd7
    } Ocp_cmd;

    // OCP SResp encodings
    typedef enum logic [1:0] {
        NULL = 2'd0,
        DVA  = 2'd1,
        FAIL = 2'd2,
        ERR  = 2'd3
    } Ocp_resp;

    // Ceiling log2, never less than 1 so an index always has at least one bit
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        if (r < 1) begin
            r = 1;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ocp_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : ocp_arbiter
//  Description : Round-robin arbiter sharing one OCP slave among N_MASTERS
//                masters. One transaction in flight at a time; RDEX/RDL
//                with a DVA response locks the slave to the issuing master
//                until that master writes.
//  Revision    : 1.0 - initial release
// ============================================================================
module ocp_arbiter #(
    parameter int N_MASTERS  = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [3*N_MASTERS-1:0]                m_mcmd,
    input  logic [ADDR_WIDTH*N_MASTERS-1:0]       m_maddr,
    input  logic [DATA_WIDTH*N_MASTERS-1:0]       m_mdata,
    output logic [N_MASTERS-1:0]                  m_scmdaccept,
    output logic [2*N_MASTERS-1:0]                m_sresp,
    output logic [DATA_WIDTH-1:0]                 m_sdata,
    output logic [2:0]                            s_mcmd,
    output logic [ADDR_WIDTH-1:0]                 s_maddr,
    output logic [DATA_WIDTH-1:0]                 s_mdata,
    input  logic                                  s_scmdaccept,
    input  logic [1:0]                            s_sresp,
    input  logic [DATA_WIDTH-1:0]                 s_sdata,
    output logic [Bus::clog2(N_MASTERS)-1:0]      grant,
    output logic                                  locked
);

    localparam int              c_gw       = Bus::clog2(N_MASTERS);
    localparam logic [c_gw-1:0] c_last_idx = c_gw'(N_MASTERS - 1);
    localparam logic [c_gw:0]   c_n        = (c_gw + 1)'(N_MASTERS);

    typedef enum logic [1:0] {
        ST_ARB  = 2'd0,
        ST_CMD  = 2'd1,
        ST_RESP = 2'd2,
        ST_LOCK = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [c_gw-1:0] r_grant;
    logic [c_gw-1:0] w_grant_nxt;
    logic [c_gw-1:0] r_rr;
    logic [c_gw-1:0] w_rr_nxt;
    logic            r_locked;
    logic            w_locked_nxt;
    logic [2:0]      r_cmd;
    logic [2:0]      w_cmd_nxt;

    logic [2:0]            w_mcmd  [N_MASTERS];
    logic [ADDR_WIDTH-1:0] w_maddr [N_MASTERS];
    logic [DATA_WIDTH-1:0] w_mdata [N_MASTERS];
    logic [N_MASTERS-1:0]  w_req;

    logic            w_found;
    logic [c_gw-1:0] w_winner;
    logic [c_gw:0]   w_pos;
    logic [2:0]      w_gcmd;
    logic            w_posted;
    logic            w_rsp_valid;
    logic            w_lock_cmd;
    logic            w_wrnp_cmd;
    logic [c_gw-1:0] w_rr_inc;

    // Split the flat per-master buses into indexable slices
    generate
        for (genvar gi = 0; gi < N_MASTERS; gi++) begin : g_unpack
            assign w_mcmd[gi]  = m_mcmd[3*gi +: 3];
            assign w_maddr[gi] = m_maddr[ADDR_WIDTH*gi +: ADDR_WIDTH];
            assign w_mdata[gi] = m_mdata[DATA_WIDTH*gi +: DATA_WIDTH];
            assign w_req[gi]   = (m_mcmd[3*gi +: 3] != Bus::IDLE);
        end
    endgenerate

    // Round-robin search: first requester at or after the rr pointer, wrapping
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_pos    = '0;
        for (int k = 0; k < N_MASTERS; k++) begin
            w_pos = {1'b0, r_rr} + (c_gw + 1)'(k);
            if (w_pos >= c_n) begin
                w_pos = w_pos - c_n;
            end
            if (!w_found && w_req[w_pos[c_gw-1:0]]) begin
                w_found  = 1'b1;
                w_winner = w_pos[c_gw-1:0];
            end
        end
    end

    assign w_gcmd      = w_mcmd[r_grant];
    assign w_posted    = (w_gcmd == Bus::WR) || (w_gcmd == Bus::BCST);
    assign w_rsp_valid = (s_sresp != Bus::NULL);
    assign w_lock_cmd  = (r_cmd == Bus::RDEX) || (r_cmd == Bus::RDL);
    assign w_wrnp_cmd  = (r_cmd == Bus::WRNP) || (r_cmd == Bus::WRC);
    assign w_rr_inc    = (r_grant == c_last_idx) ? '0 : r_grant + 1'b1;

    // Read data is broadcast; only the granted master sees a non-NULL SResp
    assign m_sdata = s_sdata;
    assign grant   = r_grant;
    assign locked  = r_locked;

    // Next-state and slave/master-side outputs
    always_comb begin
        w_state_nxt  = r_state;
        w_grant_nxt  = r_grant;
        w_rr_nxt     = r_rr;
        w_locked_nxt = r_locked;
        w_cmd_nxt    = r_cmd;
        s_mcmd       = Bus::IDLE;
        s_maddr      = '0;
        s_mdata      = '0;
        m_scmdaccept = '0;
        m_sresp      = '0;

        case (r_state)
            ST_ARB: begin
                if (w_found) begin
                    w_grant_nxt = w_winner;
                    w_state_nxt = ST_CMD;
                end
            end

            ST_CMD: begin
                s_mcmd  = w_gcmd;
                s_maddr = w_maddr[r_grant];
                s_mdata = w_mdata[r_grant];
                if (s_scmdaccept && (w_gcmd != Bus::IDLE)) begin
                    if (w_posted) begin
                        if (r_locked && (w_gcmd == Bus::WR)) begin
                            // Owner's write releases the lock at accept
                            w_locked_nxt = 1'b0;
                            w_rr_nxt     = w_rr_inc;
                            w_state_nxt  = ST_ARB;
                        end else if (r_locked) begin
                            w_state_nxt = ST_LOCK;
                        end else begin
                            w_rr_nxt    = w_rr_inc;
                            w_state_nxt = ST_ARB;
                        end
                    end else begin
                        w_cmd_nxt   = w_gcmd;
                        w_state_nxt = ST_RESP;
                    end
                end
            end

            ST_RESP: begin
                if (w_rsp_valid) begin
                    if (w_lock_cmd && (s_sresp == Bus::DVA)) begin
                        w_locked_nxt = 1'b1;
                        w_state_nxt  = ST_LOCK;
                    end else if (r_locked && w_wrnp_cmd) begin
                        w_locked_nxt = 1'b0;
                        w_rr_nxt     = w_rr_inc;
                        w_state_nxt  = ST_ARB;
                    end else if (r_locked) begin
                        w_state_nxt = ST_LOCK;
                    end else begin
                        w_rr_nxt    = w_rr_inc;
                        w_state_nxt = ST_ARB;
                    end
                end
            end

            ST_LOCK: begin
                // Only the lock owner may proceed; everyone else stalls
                if (w_req[r_grant]) begin
                    w_state_nxt = ST_CMD;
                end
            end

            default: begin
                w_state_nxt = ST_ARB;
            end
        endcase

        for (int i = 0; i < N_MASTERS; i++) begin
            if ((r_state == ST_CMD) && (r_grant == c_gw'(i))) begin
                m_scmdaccept[i] = s_scmdaccept;
            end
            if ((r_state == ST_RESP) && (r_grant == c_gw'(i))) begin
                m_sresp[2*i +: 2] = s_sresp;
            end
        end

        // Quiet bus while reset is held, whatever state was left behind
        if (!reset) begin
            s_mcmd       = Bus::IDLE;
            s_maddr      = '0;
            s_mdata      = '0;
            m_scmdaccept = '0;
            m_sresp      = '0;
        end
    end

    // State register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state  <= ST_ARB;
            r_grant  <= '0;
            r_rr     <= '0;
            r_locked <= 1'b0;
            r_cmd    <= Bus::IDLE;
        end else begin
            r_state  <= w_state_nxt;
            r_grant  <= w_grant_nxt;
            r_rr     <= w_rr_nxt;
            r_locked <= w_locked_nxt;
            r_cmd    <= w_cmd_nxt;
        end
    end

endmodule
`default_nettype wire

// File: doc/ocp_arbiter.md
Name: ocp_arbiter

Overview:
- Round-robin arbiter that shares one OCP slave port among N_MASTERS OCP master ports.
- Commands and responses use the Bus package encodings: Bus::Ocp_cmd for commands, Bus::Ocp_resp for responses.
- Serialises transactions and tracks one outstanding response-bearing transaction.
- Supports an exclusive-read lock: after RDEX or RDL, the slave is held for the issuing master until that master writes.

Parameters:
- N_MASTERS, 4, number of master ports (2..16); grant index width is Bus::clog2(N_MASTERS).
- ADDR_WIDTH, 32, MAddr width.
- DATA_WIDTH, 32, MData/SData width.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-low reset.
- m_mcmd  in  3*N_MASTERS  per-master MCmd (Bus::Ocp_cmd); slice i belongs to master i.
- m_maddr  in  ADDR_WIDTH*N_MASTERS  per-master MAddr.
- m_mdata  in  DATA_WIDTH*N_MASTERS  per-master MData.
- m_scmdaccept  out  N_MASTERS  per-master SCmdAccept.
- m_sresp  out  2*N_MASTERS  per-master SResp (Bus::Ocp_resp).
- m_sdata  out  DATA_WIDTH  SData, broadcast to all masters; valid only with that master's m_sresp != NULL.
- s_mcmd  out  3  MCmd to slave.
- s_maddr  out  ADDR_WIDTH  MAddr to slave.
- s_mdata  out  DATA_WIDTH  MData to slave.
- s_scmdaccept  in  1  slave SCmdAccept.
- s_sresp  in  2  slave SResp.
- s_sdata  in  DATA_WIDTH  slave SData.
- grant  out  Bus::clog2(N_MASTERS)  current owner index (debug).
- locked  out  1  exclusive lock active.

Behaviour:
- Reset (reset=0 at a clk edge):
  - State becomes ARB; rr pointer=0; grant=0; locked=0.
  - Outputs while in reset and in ARB: s_mcmd=IDLE, s_maddr=0, s_mdata=0, all m_scmdaccept=0, all m_sresp=NULL.
  - Reset mid-transaction abandons it; no response is forwarded.
- Command classes:
  - Posted commands WR and BCST complete on accept.
  - Response-bearing commands RD, RDEX, RDL, WRNP, WRC complete on the first s_sresp != NULL.
- ARB state:
  - Requester i means m_mcmd[i] != IDLE.
  - Search starts at rr pointer and wraps modulo N_MASTERS; the first requester wins.
  - Register grant=winner; go to CMD next cycle. This gives a 1-cycle arbitration bubble.
  - No requesters: stay in ARB.
- CMD state:
  - s_mcmd/s_maddr/s_mdata are combinationally muxed from master[grant].
  - m_scmdaccept[grant]=s_scmdaccept; all other accepts are 0.
  - On accept with a posted command: go to ARB, or to LOCK if locked=1.
  - On accept with a response-bearing command: latch the command and go to RESP.
  - Masters must hold their command until accepted; behaviour on early withdrawal is undefined.
- RESP state:
  - s_mcmd=IDLE; m_sresp[grant]=s_sresp; m_sdata=s_sdata.
  - On s_sresp != NULL, evaluate in this order:
    - If the latched command is RDEX or RDL and the response is DVA: set locked=1, go to LOCK.
    - Else if locked=1 and the latched command is WRNP or WRC: clear locked, go to ARB.
    - Else: go to LOCK if locked, otherwise ARB.
  - A FAIL or ERR response to RDEX/RDL does not set the lock.
- LOCK state:
  - Only master[grant] is considered; other requesters stall (accept=0).
  - When m_mcmd[grant] != IDLE, go to CMD.
  - A WR by the lock owner clears locked at its accept.
  - Reads by the owner keep the lock.
- rr pointer:
  - On every transaction completion that returns to ARB, rr pointer = (grant+1) mod N_MASTERS.
  - No update while locked.
- Throughput:
  - Posted back-to-back from different masters: 1 transaction per 2 cycles (ARB+CMD) with zero-wait accept.
- Responses are never routed to a master other than the grant.
- m_sresp for non-granted masters is always NULL.

Test Plan:
- Reset with all masters issuing WR -> in the reset cycle and first ARB cycle s_mcmd=IDLE and all accepts 0; grant becomes 0 one cycle after reset release; master 0 is accepted first.
- Masters 0..3 all holding WR, s_scmdaccept=1 constantly -> slave sees writes in order 0,1,2,3,0, each s_mcmd=WR every other cycle; each m_scmdaccept pulses 1 cycle.
- Master 2 issues RD at addr 0x40; slave accepts, returns DVA data 0xDEADBEEF after 3 cycles -> m_sresp[2]=DVA with m_sdata=0xDEADBEEF for exactly 1 cycle; other m_sresp stay NULL; master 1 requesting meanwhile is not accepted until after the response.
- Master 1 issues RDEX (resp DVA), then master 3 requests WR, then master 1 issues WR -> locked=1 after the RDEX response; master 3 stalls; master 1's WR is accepted; locked=0 on that accept; master 3 is served next.
- Master 0 issues RDEX, slave responds ERR -> locked stays 0; state returns to ARB; master 1's pending request is granted next.
- Reset asserted while in RESP (master 2 RD outstanding) -> next cycle state ARB, locked=0, s_mcmd=IDLE; a late s_sresp=DVA is not forwarded to any master.
